reset_sequencer: RTL

- Conditions every reset source for the MuraxArduino core into one clean, stretched reset: PLL lock, the GRESET push-button and a software reset request.
- Replaces the ad-hoc reset_counter / greset edge logic that currently drives io_asyncReset at toplevel.
- Debounces the button and synchronises all inputs to CLK.
- Holds reset while the PLL is unlocked and stretches every reset pulse to a fixed length.
- Reports the cause of the last reset and a saturating reset-event count.

---
 rtl/reset_seq_pkg.sv | 23 ++
 rtl/reset_debounce.sv | 60 ++++++
 rtl/reset_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared encodings for the reset sequencer: FSM states, reset-cause codes and
// a helper that sizes counters from their terminal counts.
package reset_seq_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_HOLD    = 2'd0;
   localparam logic [1:0] ST_STRETCH = 2'd1;
   localparam logic [1:0] ST_RUN     = 2'd2;

   // Cause of the most recent reset, as reported on reset_cause
   localparam logic [1:0] CAUSE_POR       = 2'b00;
   localparam logic [1:0] CAUSE_LOCK_LOSS = 2'b01;
   localparam logic [1:0] CAUSE_BUTTON    = 2'b10;
   localparam logic [1:0] CAUSE_SOFTWARE  = 2'b11;

   localparam int unsigned EventsW = 8;

   // Width needed to hold values 0..n-1, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reset_debounce.sv
// Synchronises the raw GRESET button, debounces it and emits a one-cycle
// pulse when the debounced level is released (1 -> 0).
module reset_debounce
   import reset_seq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic CLK,
   input  logic reset_in,
   input  logic btn_in,
   output logic btn_level,
   output logic rel_pulse
);

   localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]      sync_q;
   logic            btn_sync;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            level_q, level_d;
   logic            rel_q, rel_d;

   assign btn_sync  = sync_q[1];
   assign btn_level = level_q;
   assign rel_pulse = rel_q;

   // Level only follows the synchronised input after DEBOUNCE_CYCLES
   // consecutive disagreeing samples; any agreement restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (btn_sync == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         level_d = btn_sync;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
      // Pulse registers in the same cycle the level falls
      rel_d = level_q & ~level_d;
   end

   // Synchroniser, debounce counter, level and release pulse state
   always_ff @(posedge CLK or posedge reset_in) begin
      if (reset_in) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_in};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rel_q   <= rel_d;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Combines PLL lock, the debounced GRESET button and software requests into a
// single stretched, registered core reset, and records cause and event count.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned STRETCH_CYCLES  = 255
) (
   input  logic         CLK,
   input  logic         reset_in,
   input  logic         pll_locked,
   input  logic         btn_in,
   input  logic         sw_reset_req,
   output logic         reset_out,
   output logic [1:0]   reset_cause,
   output logic [EventsW-1:0] reset_events,
   output logic         btn_level
);

   localparam int unsigned StrW = cnt_width(STRETCH_CYCLES);
   localparam logic [StrW-1:0] StrMax = StrW'(STRETCH_CYCLES - 1);
   localparam logic [EventsW-1:0] EventsMax = '1;

   logic [1:0]         lock_sync_q;
   logic               lock_sync;
   logic               rel_pulse;
   logic [1:0]         state_q, state_d;
   logic [StrW-1:0]    str_cnt_q, str_cnt_d;
   logic [1:0]         cause_q, cause_d;
   logic [EventsW-1:0] events_q, events_d;
   logic               reset_out_q, reset_out_d;
   logic               event_inc;

   assign lock_sync    = lock_sync_q[1];
   assign reset_out    = reset_out_q;
   assign reset_cause  = cause_q;
   assign reset_events = events_q;

   reset_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .CLK       (CLK),
      .reset_in  (reset_in),
      .btn_in    (btn_in),
      .btn_level (btn_level),
      .rel_pulse (rel_pulse)
   );

   // Next-state logic: lock loss dominates, then button, then software
   always_comb begin
      state_d   = state_q;
      str_cnt_d = str_cnt_q;
      cause_d   = cause_q;
      event_inc = 1'b0;
      case (state_q)
         ST_HOLD: begin
            if (lock_sync) begin
               state_d   = ST_STRETCH;
               str_cnt_d = '0;
            end
         end
         ST_STRETCH: begin
            if (!lock_sync) begin
               state_d = ST_HOLD;
               cause_d = CAUSE_LOCK_LOSS;
            end else if (rel_pulse || sw_reset_req) begin
               // Re-trigger while stretching: restart, but it is the same event
               str_cnt_d = '0;
               cause_d   = rel_pulse ? CAUSE_BUTTON : CAUSE_SOFTWARE;
            end else if (str_cnt_q == StrMax) begin
               state_d   = ST_RUN;
               str_cnt_d = '0;
            end else begin
               str_cnt_d = str_cnt_q + StrW'(1);
            end
         end
         ST_RUN: begin
            if (!lock_sync) begin
               state_d   = ST_HOLD;
               cause_d   = CAUSE_LOCK_LOSS;
               event_inc = 1'b1;
            end else if (rel_pulse) begin
               state_d   = ST_STRETCH;
               str_cnt_d = '0;
               cause_d   = CAUSE_BUTTON;
               event_inc = 1'b1;
            end else if (sw_reset_req) begin
               state_d   = ST_STRETCH;
               str_cnt_d = '0;
               cause_d   = CAUSE_SOFTWARE;
               event_inc = 1'b1;
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase

      events_d = events_q;
      if (event_inc && (events_q != EventsMax)) begin
         events_d = events_q + EventsW'(1);
      end

      // Registered from next state so reset_out changes on the deciding edge
      reset_out_d = (state_d != ST_RUN);
   end

   // Lock synchroniser and sequencer state
   always_ff @(posedge CLK or posedge reset_in) begin
      if (reset_in) begin
         lock_sync_q <= '0;
         state_q     <= ST_HOLD;
         str_cnt_q   <= '0;
         cause_q     <= CAUSE_POR;
         events_q    <= '0;
         reset_out_q <= 1'b1;
      end else begin
         lock_sync_q <= {lock_sync_q[0], pll_locked};
         state_q     <= state_d;
         str_cnt_q   <= str_cnt_d;
         cause_q     <= cause_d;
         events_q    <= events_d;
         reset_out_q <= reset_out_d;
      end
   end

endmodule
